// File: rtl/disp_frame_writer.sv
// Walks the cell grid once per frame and writes one RGB word per pixel into the display BRAM.
// Cell read at N, colour select at N+1, registered BRAM write at N+2; one pixel per clock, no gaps.
module disp_frame_writer #(
  parameter int          COLS        = 128,
  parameter int          ROWS        = 64,
  parameter int          AW          = 13,
  parameter logic [23:0] COLOR_DEAD  = 24'h000000,
  parameter logic [23:0] COLOR_BORN  = 24'h00FF00,
  parameter logic [23:0] COLOR_ALIVE = 24'hFFFFFF,
  parameter logic [23:0] COLOR_DYING = 24'hFF0000
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          start,
  input  logic          clear,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cell_addr,
  output logic          cell_rd,
  input  logic          cell_cur,
  input  logic          cell_prev,
  output logic [AW-1:0] addr,
  output logic [23:0]   data,
  output logic          write_en
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            clr_q;
  logic            drain_last;
  logic            pipe_vld;
  logic [AW-1:0]   pipe_addr;
  logic [23:0]     color;

  assign cell_addr = {row, col};

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      clr_q      <= 1'b0;
      drain_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cell_rd    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SCAN;
            clr_q   <= clear;
            busy    <= 1'b1;
            cell_rd <= !clear;
          end
        end
        SCAN: begin
          col <= col + 1'b1;
          if (col == '1)
            row <= row + 1'b1;
          // Both counters wrap to zero on the same edge the scan ends.
          if (col == '1 && row == '1) begin
            state      <= DRAIN;
            cell_rd    <= 1'b0;
            drain_last <= 1'b0;
          end
        end
        DRAIN: begin
          drain_last <= 1'b1;
          if (drain_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    color = COLOR_DEAD;
    if (!clr_q) begin
      case ({cell_prev, cell_cur})
        2'b01:   color = COLOR_BORN;
        2'b11:   color = COLOR_ALIVE;
        2'b10:   color = COLOR_DYING;
        default: color = COLOR_DEAD;
      endcase
    end
  end

  // pipe_* marks the address whose cell bits are on cell_cur/cell_prev this cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pipe_vld  <= 1'b0;
      pipe_addr <= '0;
      addr      <= '0;
      data      <= '0;
      write_en  <= 1'b0;
    end else begin
      pipe_vld  <= (state == SCAN);
      pipe_addr <= cell_addr;
      write_en  <= pipe_vld;
      if (pipe_vld) begin
        addr <= pipe_addr;
        data <= color;
      end
    end
  end

endmodule

// File: tb/tb_disp_frame_writer.sv
// Bench for disp_frame_writer: frame-timeline model plus directed frames and literal pins.
module tb_disp_frame_writer;
  localparam int COLS = 128;
  localparam int ROWS = 64;
  localparam int AW   = 13;
  localparam int N    = COLS * ROWS;

  logic          clk_in = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          cell_cur = 1'b0;
  logic          cell_prev = 1'b0;
  logic          busy, done, cell_rd, write_en;
  logic [AW-1:0] cell_addr, addr;
  logic [23:0]   data;

  int            mode = 0;
  int            k = -1;
  logic          m_clr = 1'b0;
  bit            ew;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            writes_f = 0, busy_f = 0, rd_f = 0, nz_f = 0, first_we = -1, done_total = 0;
  logic [23:0]   seen [N];
  logic [AW-1:0] hold_a = '0;
  logic [23:0]   hold_d = '0;

  disp_frame_writer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .clear(clear),
    .busy(busy), .done(done), .cell_addr(cell_addr), .cell_rd(cell_rd),
    .cell_cur(cell_cur), .cell_prev(cell_prev),
    .addr(addr), .data(data), .write_en(write_en)
  );

  always #5 clk_in = ~clk_in;

  // {prev,cur} held in the cell store for a given address under the current pattern
  function automatic logic [1:0] pat(int a);
    if (mode == 2) return 2'b11;
    if (mode == 1) begin
      if (a == 5)    return 2'b01;
      if (a == 130)  return 2'b11;
      if (a == 8191) return 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic logic [23:0] spec_colour(logic [1:0] pc);
    case (pc)
      2'b01:   return 24'h00FF00;
      2'b11:   return 24'hFFFFFF;
      2'b10:   return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  always @(posedge clk_in) begin
    if (mode == 2)
      {cell_prev, cell_cur} <= 2'b11;
    else if (cell_rd)
      {cell_prev, cell_cur} <= pat(int'(cell_addr));
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", nm, act, exp, k, $time);
    end
  endtask

  task automatic pulse(input logic c);
    @(negedge clk_in);
    start = 1'b1;
    clear = c;
    @(negedge clk_in);
    start = 1'b0;
    clear = 1'b0;
    chk("start_accept", k, 0);
  endtask

  task automatic wait_k(input int target, input int budget, input string nm);
    int c;
    c = 0;
    while (k != target && c < budget) begin
      @(negedge clk_in);
      c++;
    end
    chk(nm, k, target);
  endtask

  initial begin
    fork
      // Frame timeline: k counts cycles since SCAN entry, -1 when idle.
      forever begin
        @(posedge clk_in or posedge rst);
        if (rst) begin
          k = -1;
          m_clr = 1'b0;
        end else if (k < 0) begin
          if (start) begin
            k = 0;
            m_clr = clear;
          end
        end else if (k == N + 2) begin
          k = -1;
        end else begin
          k++;
        end
      end
      forever begin
        @(negedge clk_in);
        ew = (k >= 2 && k <= N + 1);
        if (rst) begin
          hold_a = '0;
          hold_d = '0;
        end else if (ew) begin
          hold_a = AW'(k - 2);
          hold_d = m_clr ? 24'h0 : spec_colour(pat(k - 2));
        end
        if (k == 0) begin
          writes_f = 0; busy_f = 0; rd_f = 0; nz_f = 0; first_we = -1;
        end
        chk("busy",      busy,      (k >= 0 && k <= N + 1));
        chk("done",      done,      (k == N + 2));
        chk("write_en",  write_en,  ew);
        chk("cell_rd",   cell_rd,   (!m_clr && k >= 0 && k < N));
        chk("cell_addr", cell_addr, (k >= 0 && k < N) ? k : 0);
        chk("addr",      addr,      hold_a);
        chk("data",      data,      hold_d);
        if (busy) busy_f++;
        if (cell_rd) rd_f++;
        if (done) done_total++;
        if (write_en) begin
          writes_f++;
          if (first_we < 0) first_we = k;
          if (data != 24'h0) nz_f++;
          seen[addr] = data;
        end
      end
    join_none

    #1 rst = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", busy, 0);
    chk("rst_we", write_en, 0);
    chk("rst_data", data, 24'h0);
    rst = 1'b0;
    @(negedge clk_in);

    // all-dead frame
    mode = 0;
    pulse(1'b0);
    wait_k(N + 2, N + 20, "t1_done_wait");
    @(negedge clk_in);
    chk("t1_writes", writes_f, 8192);
    chk("t1_busy_cycles", busy_f, 8194);
    chk("t1_first_we", first_we, 2);
    chk("t1_done_total", done_total, 1);

    // sparse transitions
    mode = 1;
    pulse(1'b0);
    wait_k(N + 2, N + 20, "t2_done_wait");
    @(negedge clk_in);
    chk("t2_px5", seen[5], 24'h00FF00);
    chk("t2_px130", seen[130], 24'hFFFFFF);
    chk("t2_px8191", seen[8191], 24'hFF0000);
    chk("t2_px6", seen[6], 24'h000000);
    chk("t2_nonzero", nz_f, 3);
    chk("t2_done_total", done_total, 2);

    // clear over an all-alive store
    mode = 2;
    pulse(1'b1);
    wait_k(N + 2, N + 20, "t3_done_wait");
    @(negedge clk_in);
    chk("t3_cell_rd_cycles", rd_f, 0);
    chk("t3_nonzero", nz_f, 0);
    chk("t3_writes", writes_f, 8192);

    // starts while busy, in DONE, and just after DONE
    mode = 0;
    pulse(1'b0);
    for (int c = 0; c < N + 20 && k != N + 2; c++) begin
      @(negedge clk_in);
      start = (k == 10 || k == 500 || k == 4000);
    end
    chk("t4_reached_done", k, N + 2);
    start = 1'b1;
    @(negedge clk_in);
    chk("t4_done_once", done_total, 4);
    chk("t4_writes", writes_f, 8192);
    chk("t4_idle_after_done", k, -1);
    @(negedge clk_in);
    start = 1'b0;
    chk("t4_second_frame", k, 0);
    wait_k(N + 2, N + 20, "t4b_done_wait");
    @(negedge clk_in);
    chk("t4b_writes", writes_f, 8192);
    chk("t4b_done_total", done_total, 5);

    // reset mid-frame
    pulse(1'b0);
    for (int c = 0; c < 5000 && writes_f < 3000; c++) @(negedge clk_in);
    chk("t5_abort_point", (writes_f >= 3000), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_we", write_en, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("t5_no_done", done_total, 5);
    pulse(1'b0);
    wait_k(N + 2, N + 20, "t5_done_wait");
    @(negedge clk_in);
    chk("t5_writes", writes_f, 8192);
    chk("t5_first_we", first_we, 2);
    chk("t5_done_total", done_total, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/disp_frame_writer.md
Name: disp_frame_writer

Overview:
- Producer side of the display buffer write port: walks the Game of Life cell grid once per frame and writes one 24-bit RGB word per pixel into the 128x64 display BRAM.
- Reads current and previous generation bits from the cell store. Colours each pixel by transition: born, alive, dying or dead.
- Sits between the life engine and the display adaptor's addr/data/write_en/clk_bram_disp inputs. It runs on the same clock that drives clk_bram_disp.

Parameters:
- COLS, 128, pixels per row (power of two)
- ROWS, 64, rows per frame (power of two)
- AW, 13, address width; log2(COLS*ROWS)
- COLOR_DEAD, 24'h000000, prev=0 cur=0
- COLOR_BORN, 24'h00FF00, prev=0 cur=1
- COLOR_ALIVE, 24'hFFFFFF, prev=1 cur=1
- COLOR_DYING, 24'hFF0000, prev=1 cur=0

Ports:
- clk_in  in  1  single clock; also drives clk_bram_disp
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to write a frame
- clear  in  1  sampled with start; 1 = write COLOR_DEAD to every pixel and ignore cell data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last write
- cell_addr  out  AW  cell store read address, {row, col}
- cell_rd  out  1  cell store read enable
- cell_cur  in  1  current-generation bit, valid 1 cycle after cell_rd
- cell_prev  in  1  previous-generation bit, valid 1 cycle after cell_rd
- addr  out  AW  display BRAM write address
- data  out  24  display BRAM write data
- write_en  out  1  display BRAM write enable

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0; FSM goes to IDLE; col/row counters go to 0; the clear latch goes to 0.
  - Reset asserted mid-frame aborts the frame immediately. No further writes occur and done does not pulse. The partially written frame is left in the BRAM.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 moves to SCAN on the next edge and latches clear.
  - busy rises in the first SCAN cycle.
- SCAN:
  - Each cycle: cell_rd=1 and cell_addr={row,col}.
  - col increments each cycle; on col=COLS-1 it wraps to 0 and row increments.
  - After issuing address COLS*ROWS-1, go to DRAIN.
  - When clear is latched, cell_rd stays 0 but the address sequence and timing are identical.
- Pipeline, per address issued in cycle N:
  - N+1: cell_cur/cell_prev are sampled and the colour is selected from {prev,cur}: 00 DEAD, 01 BORN, 11 ALIVE, 10 DYING. If clear is latched, the colour is forced to DEAD.
  - N+2: addr, data and write_en=1 are presented as registered outputs. addr equals the cell_addr issued in cycle N.
  - Write throughput is one pixel per clock, with no gaps.
- DRAIN: two cycles to flush the pipeline. write_en is high in both; the final write is addr=COLS*ROWS-1.
- DONE: one cycle.
  - done=1, busy=0, write_en=0; the FSM then returns to IDLE.
  - busy falls in the same cycle that done pulses.
- Frame length: the first write occurs 2 cycles after entering SCAN. Exactly COLS*ROWS writes per frame, at strictly increasing addresses 0..COLS*ROWS-1.
- Start handling:
  - start while busy is ignored (no queueing).
  - start in the DONE cycle is ignored.
  - start in IDLE the cycle after DONE is accepted.
- write_en is 0 whenever not in SCAN (after the pipeline fills) or DRAIN. addr and data hold their last values when write_en=0.
- Counters are AW bits wide in total (log2 COLS col bits, log2 ROWS row bits). Wrap of row from ROWS-1 to 0 coincides with the transition to DRAIN.

Test Plan:
- Reset then a start pulse with all cells cur=0/prev=0 -> 8192 writes at addr 0..8191, each data=24'h000000. The first write_en is 2 cycles after the SCAN entry, done pulses once, and busy is high for 8194 cycles.
- Cell model gives {prev,cur} = 01 at addr 5, 11 at 130, 10 at 8191, 00 elsewhere -> data is 00FF00 at addr 5, FFFFFF at 130 and FF0000 at 8191; every other pixel is 000000.
- start with clear=1 over a cell store that is all alive -> cell_rd never asserts, and all 8192 writes carry 000000.
- Repeated start pulses at cycles 10, 500 and 4000 of a frame -> only one frame is written and done pulses exactly once. A start one cycle after done begins a second frame with its first write at addr 0.
- rst asserted at write 3000 -> write_en, busy and done go to 0 immediately, and no done pulse occurs. A fresh start after release writes the full 0..8191 sequence.
- Address-ordering check over a full frame -> addr increments by 1 per write_en cycle, with no duplicate or skipped addresses. Across col wrap (127 -> 128) the address is contiguous.
